button_press_classifier: RTL

// - Consumes the clean state/down/up outputs of the per-button debouncer and turns them

---
 rtl/button_press_classifier.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Purpose:
//   Turns the clean level/edge outputs of one debounced button into user-level
//   events for the stopwatch control FSM: short press, long press, release of a
//   long press and (optionally) auto-repeat ticks while a long press is held.
//
// Interface protocol:
//   There is no valid/ready handshake. btn_down/btn_up are 1-cycle pulses from
//   the debouncer, btn_state is its level. Every event output is a registered
//   1-cycle pulse with no back-pressure; the consumer must sample it on the
//   cycle it is high.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   btn_state     in   debounced level, 1 while pressed
//   btn_down      in   1-cycle pulse on debounced press
//   btn_up        in   1-cycle pulse on debounced release
//   busy          out  1 while the FSM is not IDLE (registered)
//   short_press   out  pulse: released before LONG_CYCLES elapsed
//   long_press    out  pulse: hold reached LONG_CYCLES
//   long_release  out  pulse: released after a long press
//   repeat_tick   out  pulse every REPEAT_CYCLES while held after a long press
//
// Build option:
//   BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN  - enables repeat_tick generation;
//   when undefined repeat_tick stays 0 and the counter idles in LONG.
// -----------------------------------------------------------------------------
module button_press_classifier #(
   parameter int CNT_WIDTH     = 27,
   parameter int LONG_CYCLES   = 100_000_000,
   parameter int REPEAT_CYCLES = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_state,
   input  logic btn_down,
   input  logic btn_up,
   output logic busy,
   output logic short_press,
   output logic long_press,
   output logic long_release,
   output logic repeat_tick
);

   // The counter is only ever cleared or compared against a terminal value, so
   // it must be able to represent LONG_CYCLES-1 and REPEAT_CYCLES-1.
   if (LONG_CYCLES < 1 || 64'(LONG_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_long
      $error("button_press_classifier: LONG_CYCLES does not fit in CNT_WIDTH");
   end
   if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_repeat
      $error("button_press_classifier: REPEAT_CYCLES does not fit in CNT_WIDTH");
   end

   localparam logic [CNT_WIDTH-1:0] LONG_TERM = CNT_WIDTH'(LONG_CYCLES - 1);
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] REPEAT_TERM = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_LONG    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   busy_q;
   logic                   short_q, short_d;
   logic                   long_q, long_d;
   logic                   lrel_q, lrel_d;
   logic                   tick_q, tick_d;
   logic                   release_w;

   // The level term catches a release whose btn_up pulse was missed.
   assign release_w = btn_up | ~btn_state;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      lrel_d  = 1'b0;
      tick_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (btn_down) begin
               state_d = S_PRESSED;
            end
         end
         S_PRESSED: begin
            // Release is checked first so a release on the terminal edge
            // still counts as a short press.
            if (release_w) begin
               state_d = S_IDLE;
               short_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == LONG_TERM) begin
               state_d = S_LONG;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LONG: begin
            if (release_w) begin
               state_d = S_IDLE;
               lrel_d  = 1'b1;
               cnt_d   = '0;
            end else begin
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
               if (cnt_q == REPEAT_TERM) begin
                  tick_d = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`else
               cnt_d = '0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         lrel_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         short_q <= short_d;
         long_q  <= long_d;
         lrel_q  <= lrel_d;
         tick_q  <= tick_d;
      end
   end

   assign busy         = busy_q;
   assign short_press  = short_q;
   assign long_press   = long_q;
   assign long_release = lrel_q;
   assign repeat_tick  = tick_q;

endmodule
